reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Reset controller for the async-reset flop datapath.
- Takes the board/system async active-high reset and keeps assertion asynchronous. Makes deassertion synchronous to clk.
- Releases NUM_STAGES downstream reset domains one after another, with a programmable gap between releases.
- Also services soft-reset requests that re-run the whole assert/release sequence without a hard reset.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs; range 1..16.
STAGE_DLY, 8, clk cycles between consecutive stage releases; must be >= 1.
SYNC_STAGES, 2, flops in the deassertion synchronizer; must be >= 2.
SOFT_HOLD, 16, cycles all outputs stay asserted after a soft request, before the release sequence starts; must be >= 1.

Ports:
clk  input  1  single system clock; rising edge.
reset  input  1  asynchronous, active-high system reset; asserts instantly, deasserts via synchronizer.
soft_req  input  1  single-cycle soft-reset request pulse.
soft_ack  output  1  one-cycle pulse when a soft-reset sequence completes.
rst_out  output  NUM_STAGES  active-high domain resets; bit 0 released first.
rst_done  output  1  high when all rst_out bits are released.
busy  output  1  high whenever the sequencer is not in DONE.

Behaviour:
- reset high, asynchronously and with no clock needed:
  - rst_out = all 1, rst_done = 0, soft_ack = 0, busy = 1.
  - Synchronizer chain cleared; state = SYNC; counters = 0; pending flag = 0.
- SYNC state:
  - A 1 shifts through SYNC_STAGES flops.
  - The edge on which the last flop becomes 1 enters STAGE with cnt = 0 and idx = 0.
- STAGE state:
  - cnt increments each edge. When cnt reaches STAGE_DLY-1, rst_out[idx] clears, cnt returns to 0 and idx increments.
  - The edge that clears rst_out[NUM_STAGES-1] also sets rst_done = 1 and moves to DONE.
- Hard-reset timing, counting rising edges from the first edge with reset low:
  - rst_out[k] clears on edge SYNC_STAGES + (k+1)*STAGE_DLY.
  - Defaults: 10, 18, 26, 34; rst_done rises at 34.
- DONE state: outputs stable. A soft_req high, or a set pending flag, on edge E moves to HOLD. After edge E:
  - rst_out = all 1, rst_done = 0, busy = 1, cnt = 0.
- HOLD state: after SOFT_HOLD edges, go to STAGE with idx = 0. The release sequence is identical to the hard-reset one.
- Soft-reset timing: rst_out[k] clears at E + SOFT_HOLD + (k+1)*STAGE_DLY.
  - Defaults: E+24, E+32, E+40, E+48.
  - soft_ack pulses for exactly one cycle, registered on the same edge rst_done rises (E+48).
- soft_req while busy:
  - Sets the pending flag. Multiple pulses merge into one pending request.
  - The pending request is serviced on the first DONE cycle, and the flag clears on that entry to HOLD.
- soft_req in the same cycle as a pending-service: counts as a single request.
- Hard-reset outcomes:
  - A hard reset after a soft request produces no soft_ack.
  - Hard reset mid-sequence (any state): immediate return to the full reset values; pending request lost.
- Width rules:
  - cnt width = $clog2(max(STAGE_DLY, SOFT_HOLD) + 1).
  - idx width = $clog2(NUM_STAGES + 1).
  - No wrap: idx never exceeds NUM_STAGES-1 in STAGE.
- All outputs are registered; none are combinational from soft_req.

Optional Feature:
- RST_SEQ_CNT_EN defined:
  - Adds output soft_rst_cnt [7:0]. It increments on every soft_ack pulse and saturates at 255.
  - Cleared only by reset.
- RST_SEQ_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package rst_seq_pkg holds:
  - State encoding localparams/typedef: ST_SYNC = 0, ST_HOLD = 1, ST_STAGE = 2, ST_DONE = 3.
  - Counter-width helper function.
  - Default parameter constants.
- Sub-module reset_synchronizer (params SYNC_STAGES; ports clk, reset, rst_sync_n):
  - Async assert, sync deassert.
  - Instantiated once; the FSM waits on its output.

Test Plan:
- Hard reset release, defaults: reset high for 3 cycles then low -> rst_out 4'b1111, then rst_out[0..3] clear at edges 10/18/26/34; rst_done = 1 at 34; busy = 0 after.
- Soft reset in DONE: soft_req pulse at edge E -> rst_out = 4'b1111 at E+1; releases at E+24/32/40/48; soft_ack is a single-cycle pulse at E+48.
- Request while busy: two soft_req pulses during the hard-reset release -> exactly one soft sequence starts on the first DONE edge; one soft_ack total.
- Async assert mid-sequence: assert reset between clock edges during the soft-release sequence (e.g. E+30) -> rst_out = 4'b1111 and rst_done = 0 before the next edge; no soft_ack; sequence restarts from SYNC.
- Param sweep: NUM_STAGES=1, STAGE_DLY=1, SYNC_STAGES=3 -> rst_out[0] and rst_done at edge 4.
- RST_SEQ_CNT_EN: 257 soft resets -> soft_rst_cnt = 255; hard reset -> 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared state encoding, default parameters and counter-width helper for reset_sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_STAGE = 2'd2,
      ST_DONE  = 2'd3
   } rst_state_e;

   localparam int DEF_NUM_STAGES  = 4;
   localparam int DEF_STAGE_DLY   = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SOFT_HOLD   = 16;

   function automatic int cnt_width(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Reset bridge: rst_sync_n drops asynchronously with reset and rises SYNC_STAGES
// clk edges after reset is released.
module reset_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   output logic rst_sync_n
);

   logic [SYNC_STAGES-1:0] r_chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_sync_n = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset controller: async assert, synchronized staged release, soft-reset replay.
// Define RST_SEQ_CNT_EN to add the saturating soft_rst_cnt output.
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int STAGE_DLY   = DEF_STAGE_DLY,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int SOFT_HOLD   = DEF_SOFT_HOLD
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  soft_req,
   output logic                  soft_ack,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  rst_done,
`ifdef RST_SEQ_CNT_EN
   output logic [7:0]            soft_rst_cnt,
`endif
   output logic                  busy
);

   localparam int CW = cnt_width(STAGE_DLY, SOFT_HOLD);
   localparam int IW = $clog2(NUM_STAGES + 1);
   localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DLY - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(SOFT_HOLD - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

   rst_state_e            r_state, w_state_next;
   logic [CW-1:0]         r_cnt, w_cnt_next;
   logic [IW-1:0]         r_idx, w_idx_next;
   logic                  r_pend, w_pend_next;
   logic                  r_soft_seq, w_soft_seq_next;
   logic [NUM_STAGES-1:0] r_rst_out, w_rst_out_next;
   logic                  r_rst_done, w_rst_done_next;
   logic                  r_soft_ack, w_ack_next;
   logic                  r_busy;
   logic                  w_sync_n, w_stage_step, w_enter_hold, w_release, w_last;

   reset_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .reset      (reset),
      .rst_sync_n (w_sync_n)
   );

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_idx_next      = r_idx;
      w_pend_next     = r_pend;
      w_soft_seq_next = r_soft_seq;
      w_enter_hold    = 1'b0;
      w_release       = 1'b0;
      w_last          = 1'b0;
      // SYNC with the chain released acts as STAGE at cnt=0/idx=0, so the state
      // change lands on the same edge the last synchronizer flop goes high.
      w_stage_step    = (r_state == ST_STAGE) || ((r_state == ST_SYNC) && w_sync_n);

      if (soft_req && (r_state != ST_DONE)) begin
         w_pend_next = 1'b1;
      end

      case (r_state)
         ST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_next = ST_STAGE;
               w_cnt_next   = '0;
               w_idx_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_DONE: begin
            if (soft_req || r_pend) begin
               w_state_next    = ST_HOLD;
               w_cnt_next      = '0;
               w_pend_next     = 1'b0;
               w_soft_seq_next = 1'b1;
               w_enter_hold    = 1'b1;
            end
         end
         default: ;
      endcase

      if (w_stage_step) begin
         w_state_next = ST_STAGE;
         if (r_cnt == DLY_LAST) begin
            w_cnt_next = '0;
            w_release  = 1'b1;
            if (r_idx == IDX_LAST) begin
               w_last       = 1'b1;
               w_state_next = ST_DONE;
            end else begin
               w_idx_next = r_idx + 1'b1;
            end
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end

      if (w_last) begin
         w_soft_seq_next = 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_out
         assign w_rst_out_next[gi] = w_enter_hold ? 1'b1 :
                                     (w_release && (r_idx == IW'(gi))) ? 1'b0 : r_rst_out[gi];
      end
   endgenerate

   assign w_rst_done_next = w_last ? 1'b1 : (w_enter_hold ? 1'b0 : r_rst_done);
   assign w_ack_next      = w_last && r_soft_seq;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_SYNC;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_pend     <= 1'b0;
         r_soft_seq <= 1'b0;
         r_rst_out  <= '1;
         r_rst_done <= 1'b0;
         r_soft_ack <= 1'b0;
         r_busy     <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_idx      <= w_idx_next;
         r_pend     <= w_pend_next;
         r_soft_seq <= w_soft_seq_next;
         r_rst_out  <= w_rst_out_next;
         r_rst_done <= w_rst_done_next;
         r_soft_ack <= w_ack_next;
         r_busy     <= (w_state_next != ST_DONE);
      end
   end

`ifdef RST_SEQ_CNT_EN
   logic [7:0] r_soft_rst_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_soft_rst_cnt <= '0;
      end else if (w_ack_next && (r_soft_rst_cnt != 8'hFF)) begin
         r_soft_rst_cnt <= r_soft_rst_cnt + 8'd1;
      end
   end

   assign soft_rst_cnt = r_soft_rst_cnt;
`endif

   assign rst_out  = r_rst_out;
   assign rst_done = r_rst_done;
   assign soft_ack = r_soft_ack;
   assign busy     = r_busy;

endmodule
